// File: rtl/conv2d_engine.sv
//==============================================================================
// Module      : conv2d_engine
// Description : Single-layer 2D convolution engine. Loads one KxK weight set
//               at a time into an internal bank, then sweeps a valid-padded,
//               strided window over a square image held in external
//               synchronous memory, using a single signed MAC. Each
//               result is arithmetically shifted by FRAC_BITS, saturated
//               to DATA_W and written to an output memory in ascending
//               address order (filter, row, column).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   begin a job (only looked at in IDLE)
//   busy         out  high from the cycle after start is taken until done
//   done         out  one-cycle pulse after the final output write
//   img_address  out  image read address  (row*IMG_DIM + col), registered
//   img_data     in   image read data, one cycle after img_address
//   wt_address   out  weight read address (f*K*K + kr*K + kc), registered
//   wt_data      in   weight read data, one cycle after wt_address
//   out_address  out  output address (f*OUT_DIM^2 + r*OUT_DIM + c)
//   out_data     out  saturated result
//   out_wen      out  output write strobe, one cycle per result
//
// Build option:
//   CONV2D_RELU_EN  when defined, negative saturated results are written as 0
//==============================================================================
`default_nettype none

module conv2d_engine #(
  parameter int DATA_W    = 16,
  parameter int IMG_DIM   = 8,
  parameter int K         = 3,
  parameter int STRIDE    = 1,
  parameter int N_FILTERS = 4,
  parameter int FRAC_BITS = 16,
  localparam int OUT_DIM  = (IMG_DIM - K) / STRIDE + 1,
  localparam int KK       = K * K,
  localparam int ACC_W    = 2 * DATA_W + $clog2(KK),
  localparam int IMG_AW   = (IMG_DIM * IMG_DIM > 1) ? $clog2(IMG_DIM * IMG_DIM) : 1,
  localparam int WT_AW    = (N_FILTERS * KK > 1) ? $clog2(N_FILTERS * KK) : 1,
  localparam int OUT_AW   = (N_FILTERS * OUT_DIM * OUT_DIM > 1) ?
                            $clog2(N_FILTERS * OUT_DIM * OUT_DIM) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IMG_AW-1:0] img_address,
  input  logic [DATA_W-1:0] img_data,
  output logic [WT_AW-1:0]  wt_address,
  input  logic [DATA_W-1:0] wt_data,
  output logic [OUT_AW-1:0] out_address,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wen
);

  localparam int CW    = 16;
  localparam int TAP_W = (KK > 1) ? $clog2(KK) : 1;

  localparam logic [CW-1:0]    K_M1   = CW'(K - 1);
  localparam logic [CW-1:0]    OD_M1  = CW'(OUT_DIM - 1);
  localparam logic [CW-1:0]    F_M1   = CW'(N_FILTERS - 1);
  localparam logic [TAP_W-1:0] KK_M1  = TAP_W'(KK - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_W     = 3'd1,
    S_LOAD_DRAIN = 3'd2,
    S_CONV       = 3'd3,
    S_DRAIN      = 3'd4,
    S_WRITE      = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  // Sweep counters
  logic [CW-1:0]    r_f, r_r, r_c, r_kr, r_kc;
  logic [TAP_W-1:0] r_tap;
  logic [1:0]       r_cnt;

  logic [IMG_AW-1:0] r_img_address;
  logic [WT_AW-1:0]  r_wt_address;
  logic [OUT_AW-1:0] r_out_address;

  // Read-return tags: stage 1 = address on the bus, stage 2 = data on the
  // bus, stage 3 = data captured in r_img_q / r_wt_q and ready to use.
  logic             r_p1_w, r_p2_w, r_p3_w;
  logic             r_p1_i, r_p2_i, r_p3_i;
  logic [TAP_W-1:0] r_p1_tap, r_p2_tap, r_p3_tap;

  logic signed [DATA_W-1:0] r_img_q;
  logic signed [DATA_W-1:0] r_wt_q;
  logic signed [DATA_W-1:0] r_bank [KK];
  logic signed [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0]        r_out_data;

  logic                      w_last_tap;
  logic                      w_last_pix;
  logic [TAP_W-1:0]          w_tap_next;
  logic [CW-1:0]             w_kr_next, w_kc_next;
  logic [IMG_AW-1:0]         w_img_addr;
  logic [WT_AW-1:0]          w_wt_addr;
  logic [OUT_AW-1:0]         w_out_addr;
  logic signed [DATA_W-1:0]  w_wt_tap;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_acc_base;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [ACC_W-1:0]   w_shift;
  logic [DATA_W-1:0]         w_sat;
  logic [DATA_W-1:0]         w_res;

  assign w_last_tap = (r_tap == KK_M1);
  assign w_last_pix = (r_r == OD_M1) && (r_c == OD_M1);

  assign w_img_addr = IMG_AW'((32'(r_r) * 32'(STRIDE) + 32'(r_kr)) * 32'(IMG_DIM)
                              + 32'(r_c) * 32'(STRIDE) + 32'(r_kc));
  assign w_wt_addr  = WT_AW'(32'(r_f) * 32'(KK) + 32'(r_tap));
  assign w_out_addr = OUT_AW'(32'(r_f) * 32'(OUT_DIM * OUT_DIM)
                              + 32'(r_r) * 32'(OUT_DIM) + 32'(r_c));

  // Kernel tap walk, kr-major, shared by weight load and convolution
  always_comb begin
    w_tap_next = r_tap + TAP_W'(1);
    w_kr_next  = r_kr;
    w_kc_next  = r_kc + CW'(1);
    if (w_last_tap) begin
      w_tap_next = '0;
      w_kr_next  = '0;
      w_kc_next  = '0;
    end else if (r_kc == K_M1) begin
      w_kc_next = '0;
      w_kr_next = r_kr + CW'(1);
    end
  end

  //--------------------------------------------------------------------------
  // FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next = S_LOAD_W;
      S_LOAD_W:     if (w_last_tap) w_next = S_LOAD_DRAIN;
      S_LOAD_DRAIN: if (r_cnt == 2'd1) w_next = S_CONV;
      S_CONV:       if (w_last_tap) w_next = S_DRAIN;
      S_DRAIN:      if (r_cnt == 2'd2) w_next = S_WRITE;
      S_WRITE: begin
        if (!w_last_pix)       w_next = S_CONV;
        else if (r_f == F_M1)  w_next = S_DONE;
        else                   w_next = S_LOAD_W;
      end
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Counters and address registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_f           <= '0;
      r_r           <= '0;
      r_c           <= '0;
      r_kr          <= '0;
      r_kc          <= '0;
      r_tap         <= '0;
      r_cnt         <= '0;
      r_img_address <= '0;
      r_wt_address  <= '0;
      r_out_address <= '0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f   <= '0;
            r_r   <= '0;
            r_c   <= '0;
            r_kr  <= '0;
            r_kc  <= '0;
            r_tap <= '0;
          end
        end
        S_LOAD_W: begin
          r_wt_address <= w_wt_addr;
          r_tap        <= w_tap_next;
          r_kr         <= w_kr_next;
          r_kc         <= w_kc_next;
        end
        S_LOAD_DRAIN: begin
          r_cnt <= r_cnt + 2'd1;
        end
        S_CONV: begin
          r_img_address <= w_img_addr;
          r_tap         <= w_tap_next;
          r_kr          <= w_kr_next;
          r_kc          <= w_kc_next;
        end
        S_DRAIN: begin
          r_cnt <= r_cnt + 2'd1;
          // Address is settled just before the write strobe and then held
          if (r_cnt == 2'd2) r_out_address <= w_out_addr;
        end
        S_WRITE: begin
          if (r_c == OD_M1) begin
            r_c <= '0;
            if (r_r == OD_M1) begin
              r_r <= '0;
              r_f <= r_f + CW'(1);
            end else begin
              r_r <= r_r + CW'(1);
            end
          end else begin
            r_c <= r_c + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Read return pipeline and MAC
  //--------------------------------------------------------------------------
  assign w_wt_tap   = r_bank[r_p3_tap];
  assign w_prod     = r_img_q * w_wt_tap;
  // First tap of a pixel starts from zero so nothing carries between pixels
  assign w_acc_base = (r_p3_tap == '0) ? '0 : r_acc;
  assign w_acc_next = w_acc_base + ACC_W'(w_prod);
  assign w_shift    = w_acc_next >>> FRAC_BITS;

  always_comb begin
    w_sat = w_shift[DATA_W-1:0];
    if (w_shift > SAT_MAX) begin
      w_sat = D_MAX;
    end else if (w_shift < SAT_MIN) begin
      w_sat = D_MIN;
    end
  end

  always_comb begin
`ifdef CONV2D_RELU_EN
    w_res = w_sat[DATA_W-1] ? '0 : w_sat;
`else
    w_res = w_sat;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_p1_w     <= 1'b0;
      r_p2_w     <= 1'b0;
      r_p3_w     <= 1'b0;
      r_p1_i     <= 1'b0;
      r_p2_i     <= 1'b0;
      r_p3_i     <= 1'b0;
      r_p1_tap   <= '0;
      r_p2_tap   <= '0;
      r_p3_tap   <= '0;
      r_img_q    <= '0;
      r_wt_q     <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      r_p1_w   <= (r_state == S_LOAD_W);
      r_p1_i   <= (r_state == S_CONV);
      r_p1_tap <= r_tap;
      r_p2_w   <= r_p1_w;
      r_p2_i   <= r_p1_i;
      r_p2_tap <= r_p1_tap;
      r_p3_w   <= r_p2_w;
      r_p3_i   <= r_p2_i;
      r_p3_tap <= r_p2_tap;
      r_img_q  <= img_data;
      r_wt_q   <= wt_data;
      if (r_p3_i) begin
        r_acc <= w_acc_next;
        if (r_p3_tap == KK_M1) r_out_data <= w_res;
      end
    end
  end

  // Weight bank needs no reset: every slot is rewritten before it is read
  always_ff @(posedge clock) begin
    if (r_p3_w) r_bank[r_p3_tap] <= r_wt_q;
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign out_wen     = (r_state == S_WRITE);
  assign img_address = r_img_address;
  assign wt_address  = r_wt_address;
  assign out_address = r_out_address;
  assign out_data    = r_out_data;

endmodule

`default_nettype wire

// File: doc/conv2d_engine.md
Name: conv2d_engine

Overview:
Parametrised single-layer 2D convolution engine, successor to the fixed 3x3, four-quadrant CNN datapath. It reads a square input image and N_FILTERS KxK weight sets from external synchronous memories, and computes valid-padded, strided convolutions with one MAC. Each result is scaled, saturated and written to an output memory. The sequencer drives it through a start/busy/done handshake instead of free-running from reset.

Parameters:
DATA_W, 16, signed pixel/weight/output width
IMG_DIM, 8, input image side length
K, 3, kernel side length (K <= IMG_DIM)
STRIDE, 1, convolution stride (>= 1)
N_FILTERS, 4, number of weight sets / output maps
FRAC_BITS, 16, arithmetic right shift applied to accumulator before saturation
Derived: OUT_DIM = (IMG_DIM-K)/STRIDE+1; ACC_W = 2*DATA_W + clog2(K*K); IMG_AW = clog2(IMG_DIM^2); WT_AW = clog2(N_FILTERS*K*K); OUT_AW = clog2(N_FILTERS*OUT_DIM^2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin job; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  single-cycle pulse when the last output write completes
img_address  out  IMG_AW  image read address, registered, row*IMG_DIM+col
img_data  in  DATA_W  image read data, valid the cycle after img_address presented
wt_address  out  WT_AW  weight address, registered, f*K*K+kr*K+kc
wt_data  in  DATA_W  weight read data, valid the cycle after wt_address presented
out_address  out  OUT_AW  output address, f*OUT_DIM^2+r*OUT_DIM+c
out_data  out  DATA_W  output value
out_wen  out  1  output write strobe, one cycle per result

Behaviour:
- Reset (async, any state): FSM->IDLE; all counters 0; busy, done, out_wen 0; all addresses 0; out_data 0; weight bank contents don't-care.
- Read data is registered inside the block on arrival. Effective address-to-use latency is 2 cycles, as in the existing datapath.
- FSM states: IDLE, LOAD_W, LOAD_DRAIN, CONV, DRAIN, WRITE, DONE.
- IDLE: start=1 -> LOAD_W, f=0. start is ignored in every other state.
- LOAD_W: K*K cycles, one wt_address per cycle in kr-major order. Each returned word lands in internal bank slot kr*K+kc. Then LOAD_DRAIN (2 cycles) -> CONV with r=c=0.
- CONV: K*K cycles, img_address=(r*STRIDE+kr)*IMG_DIM+(c*STRIDE+kc), kr-major. MAC multiplies returned pixel by bank[kr*K+kc], signed full-precision. Accumulator clears on the first tap of each pixel (no stale carry between pixels).
- DRAIN: 3 cycles (2 read latency + 1 MAC register). Then WRITE.
- WRITE: 1 cycle with out_wen=1. out_data = sat_DATA_W(acc >>> FRAC_BITS), signed saturation to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Order after WRITE: advance c, then r. At r=c=OUT_DIM-1, advance f: if f<N_FILTERS-1 go to LOAD_W, else go to DONE.
- DONE: done=1 for one cycle, busy=0 in that cycle, -> IDLE.
- Busy cycles (start accepted to done, exclusive) = N_FILTERS*((K*K+2) + OUT_DIM^2*(K*K+4)).
- Writes are strictly in ascending out_address order. No address is written twice.
- img_address and wt_address hold their last value outside active issue cycles. out_address holds between writes.
- A start asserted in the same cycle as done is ignored. It must be re-asserted while in IDLE.

Optional Feature:
Macro CONV2D_RELU_EN. When defined, a negative saturated result is written as 0, matching the existing ReLU on output data. When undefined, signed saturated results are written unmodified.

Test Plan:
- IMG_DIM=4, K=3, STRIDE=1, N_FILTERS=2, FRAC_BITS=0; image all 1, weights all 1 -> 8 writes, addresses 0..7, each out_data=9; done after exactly 126 busy cycles.
- Same config, filter 1 weights all 16'hFFFF (-1) -> addresses 4..7 =16'hFFF7 (-9) without CONV2D_RELU_EN, 0 with it; filter 0 unaffected.
- FRAC_BITS=0, image and weights all 16'h7FFF -> every out_data=16'h7FFF (positive saturation). Image 16'h8000, weights 16'h7FFF -> 16'h8000 without ReLU.
- IMG_DIM=5, K=3, STRIDE=2, N_FILTERS=1, image pixel=row*5+col, centre weight 1, others 0 -> 4 writes: 6, 8, 16, 18.
- Reset asserted mid-CONV -> busy/out_wen drop asynchronously, no further writes. A new start runs a full job from f=0 with correct results.
- start held high through a full job -> exactly one job. A second job starts only after IDLE is re-entered.
